// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32IM divider:
// funct3 encodings, FSM states and the iteration counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    FN_DIV  = 2'b00,
    FN_DIVU = 2'b01,
    FN_REM  = 2'b10,
    FN_REMU = 2'b11
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Width of the iteration counter; it only has to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/cond_negate.sv
// WIDTH-generic conditional two's-complement negator: out = neg ? -in : in.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  // Purely combinational select between the operand and its negation
  always_comb begin
    if (neg_i) begin
      out_o = ~in_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      out_o = in_i;
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: magnitudes in,
// one quotient bit per cycle, sign restored in a single fixup cycle.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       funct_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state_q, state_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              sel_rem_q, sel_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic              is_signed_s;
  logic              dvd_neg_s, dvs_neg_s;
  logic [WIDTH-1:0]  dvd_mag_s, dvs_mag_s;
  logic [WIDTH-1:0]  quo_fix_s, rem_fix_s;
  logic              div_zero_s, overflow_s;
  logic [WIDTH+1:0]  shifted_s, trial_s;

  assign is_signed_s = ~funct_i[0];
  assign dvd_neg_s   = is_signed_s & dividend_i[WIDTH-1];
  assign dvs_neg_s   = is_signed_s & divisor_i[WIDTH-1];
  assign div_zero_s  = (divisor_i == ALL_ZERO);
  assign overflow_s  = is_signed_s & (dividend_i == MOST_NEG) & (divisor_i == ALL_ONES);

  cond_negate #(.WIDTH(WIDTH)) u_dvd_mag (
    .in_i (dividend_i),
    .neg_i(dvd_neg_s),
    .out_o(dvd_mag_s)
  );

  cond_negate #(.WIDTH(WIDTH)) u_dvs_mag (
    .in_i (divisor_i),
    .neg_i(dvs_neg_s),
    .out_o(dvs_mag_s)
  );

  cond_negate #(.WIDTH(WIDTH)) u_quo_fix (
    .in_i (quo_q),
    .neg_i(neg_quo_q),
    .out_o(quo_fix_s)
  );

  cond_negate #(.WIDTH(WIDTH)) u_rem_fix (
    .in_i (rem_q[WIDTH-1:0]),
    .neg_i(neg_rem_q),
    .out_o(rem_fix_s)
  );

  // The extra guard bit makes the trial's sign bit an exact borrow flag.
  assign shifted_s = {rem_q, quo_q[WIDTH-1]};
  assign trial_s   = shifted_s - {2'b00, dvsr_q};

  // Next-state, datapath and output logic for the divider FSM
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          neg_quo_d = dvd_neg_s ^ dvs_neg_s;
          neg_rem_d = dvd_neg_s;
          sel_rem_d = funct_i[1];
          dvsr_d    = dvs_mag_s;
          quo_d     = dvd_mag_s;
          rem_d     = {(WIDTH+1){1'b0}};
          cnt_d     = CNT_INIT;
          if (div_zero_s) begin
            result_d = funct_i[1] ? dividend_i : ALL_ONES;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else if (overflow_s) begin
            result_d = funct_i[1] ? ALL_ZERO : dividend_i;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else begin
            state_d  = ST_CALC;
            busy_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        busy_d = 1'b1;
        if (!trial_s[WIDTH+1]) begin
          rem_d = trial_s[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIXUP: begin
        result_d = sel_rem_q ? rem_fix_s : quo_fix_s;
        state_d  = ST_DONE;
        done_d   = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rem_q     <= {(WIDTH+1){1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dvsr_q    <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed RV32IM corner cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_div_iter_unit;

  localparam int W = 32;
  localparam int NORMAL_EDGES = W + 1;
  localparam int MAX_WAIT = 100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   funct;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks;
  int failures;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .funct_i   (funct),
    .dividend_i(dividend),
    .divisor_i (divisor),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input logic [1:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int signed sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
      return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_edges(input logic [1:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (b == 32'd0) return 0;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return NORMAL_EDGES;
  endfunction

  // Issue one operation; edges counts clock edges after the accepting edge until DONE.
  task automatic do_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int edges, output int busy_cnt,
                       output bit overlap, output bit timeout);
    bit seen;
    res = '0; edges = -1; busy_cnt = 0; overlap = 1'b0; timeout = 1'b0; seen = 1'b0;
    @(negedge clk);
    funct = f; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < MAX_WAIT && !seen; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy && done) overlap = 1'b1;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        edges = n;
        res = result;
      end
    end
    if (!seen) timeout = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; funct = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0]   fs [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
    logic [W-1:0] as [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs [8] = '{32'h2, 32'h2, 32'h10, 32'h10, 32'h0, 32'h0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] exp_r [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0000_000F,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
    int exp_e [8] = '{NORMAL_EDGES, NORMAL_EDGES, NORMAL_EDGES, NORMAL_EDGES, 0, 0, 0, 0};
    int exp_b [8] = '{W + 1, W + 1, W + 1, W + 1, 0, 0, 0, 0};
    logic [W-1:0] res;
    int edges, bcnt;
    bit ovl, tmo;
    for (int i = 0; i < 8; i++) begin
      do_op(fs[i], as[i], bs[i], res, edges, bcnt, ovl, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL dir%0d_timeout no DONE within %0d cycles", i, MAX_WAIT); end
      checks++; if (res !== exp_r[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, exp_r[i]); end
      checks++; if (edges !== exp_e[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, edges, exp_e[i]); end
      checks++; if (bcnt !== exp_b[i]) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcnt, exp_b[i]); end
      checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_done_overlap got=1 exp=0", i); end
    end
  endtask

  task automatic test_random;
    logic [1:0] f;
    logic [W-1:0] a, b, res, exp_res;
    int edges, bcnt, exp_ed;
    bit ovl, tmo;
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: ;
      endcase
      exp_res = ref_result(f, a, b);
      exp_ed  = ref_edges(f, a, b);
      do_op(f, a, b, res, edges, bcnt, ovl, tmo);
      checks++; if (res !== exp_res) begin failures++; $display("FAIL rnd%0d_result f=%b a=%h b=%h got=%h exp=%h", i, f, a, b, res, exp_res); end
      checks++; if (edges !== exp_ed) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, edges, exp_ed); end
      checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy_done_overlap got=1 exp=0", i); end
    end
  endtask

  task automatic test_start_while_busy;
    int done_cnt, done_at;
    logic [W-1:0] res;
    done_cnt = 0; done_at = -1; res = '0;
    @(negedge clk);
    funct = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (done) begin done_cnt++; done_at = 0; res = result; end
    for (int n = 1; n < 80; n++) begin
      @(negedge clk);
      if (n == 10) begin
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin done_cnt++; done_at = n; res = result; end
    end
    start = 1'b0;
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL swb_done_count got=%0d exp=1", done_cnt); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL swb_result got=%0d exp=14", res); end
    checks++; if (done_at !== NORMAL_EDGES) begin failures++; $display("FAIL swb_latency got=%0d exp=%0d", done_at, NORMAL_EDGES); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL swb_result_hold got=%0d exp=14", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    logic [W-1:0] res;
    int edges, bcnt;
    bit ovl, tmo;
    done_cnt = 0;
    @(negedge clk);
    funct = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rstmid_stale_done got=%0d exp=0", done_cnt); end
    do_op(2'b00, 32'hFFFF_FF9C, 32'h0000_000A, res, edges, bcnt, ovl, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rstmid_after_timeout no DONE within %0d cycles", MAX_WAIT); end
    checks++; if (res !== 32'hFFFF_FFF6) begin failures++; $display("FAIL rstmid_after_result got=%h exp=FFFFFFF6", res); end
    checks++; if (edges !== NORMAL_EDGES) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=%0d", edges, NORMAL_EDGES); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
